// File: rtl/dac_channel_scheduler.sv
// Round-robin scheduler that feeds one pending 12-bit value per channel to the SPI DAC wrapper.
// Performs exactly one wrapper transaction per grant and abandons a stalled frame after TIMEOUT cycles.
module dac_channel_scheduler #(
  parameter int         NCH     = 4,
  parameter logic [3:0] CMD     = 4'h3,
  parameter int         TIMEOUT = 4095
) (
  input  logic              CLK50MHZ,
  input  logic              RST,
  input  logic [NCH-1:0]    wr,
  input  logic [NCH*12-1:0] wdata,
  output logic [NCH-1:0]    pending,
  output logic [NCH-1:0]    done_ch,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [11:0]       data,
  output logic [3:0]        address,
  output logic [3:0]        command,
  output logic              dactrig,
  input  logic              dacdone,
  output logic [1:0]        state_dbg,
  output logic [3:0]        rr_ptr_dbg
);

  // Wrapper handshake: dactrig is a 1-cycle start pulse issued only when dacdone is high;
  // dacdone falls while the frame shifts and rises again when the frame is complete.
  // data/address/command are held stable from the start pulse until the frame ends.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t         state, state_n;
  logic [NCH-1:0] pend;
  logic [11:0]    val [NCH];
  logic [3:0]     rr_ptr;
  logic [CW-1:0]  cnt;
  logic [3:0]     gnt_sel;
  logic           gnt_any;
  logic [4:0]     scan;
  logic           do_grant, do_done, do_timeout;
  logic           timeout_hit;

  assign timeout_hit = (cnt >= CNT_LAST);

  // First pending channel at or after rr_ptr, wrapping modulo NCH.
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = '0;
    scan    = '0;
    for (int k = 0; k < NCH; k++) begin
      scan = {1'b0, rr_ptr} + 5'(k);
      if (scan >= 5'(NCH)) scan = scan - 5'(NCH);
      if (!gnt_any && pend[scan[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_sel = scan[3:0];
      end
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (!RST) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    do_grant   = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any && dacdone) begin
          do_grant = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: state_n = WAIT_BUSY;
      WAIT_BUSY: begin
        // Timeout is checked first so the counter can never step past its limit.
        if (timeout_hit) begin
          do_timeout = 1'b1;
          state_n    = IDLE;
        end else if (!dacdone) begin
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (dacdone) begin
          do_done = 1'b1;
          state_n = IDLE;
        end else if (timeout_hit) begin
          do_timeout = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHZ) begin
    if (!RST) begin
      pend        <= '0;
      data        <= '0;
      address     <= '0;
      command     <= CMD;
      done_ch     <= '0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      cnt         <= '0;
      for (int i = 0; i < NCH; i++) val[i] <= '0;
    end else begin
      done_ch <= '0;
      if (do_grant) begin
        data    <= val[gnt_sel[PW-1:0]];
        address <= gnt_sel;
        command <= CMD;
        cnt     <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
      end
      // A completed or timed-out grant both advance the pointer; a timed-out value is dropped.
      if (do_done || do_timeout)
        rr_ptr <= (address == 4'(NCH - 1)) ? 4'd0 : address + 4'd1;
      if (do_done)
        done_ch <= NCH'(1) << address;
      if (do_timeout)   timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      // A write landing on the grant edge keeps the channel pending with its new value.
      for (int i = 0; i < NCH; i++) begin
        if (wr[i]) begin
          pend[i] <= 1'b1;
          val[i]  <= wdata[12*i +: 12];
        end else if (do_grant && gnt_sel == 4'(i)) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  assign pending    = pend;
  assign busy       = (state != IDLE);
  assign dactrig    = (state == ISSUE);
  assign state_dbg  = state;
  assign rr_ptr_dbg = rr_ptr;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Directed bench for dac_channel_scheduler: a wrapper model drives dacdone, a monitor logs every
// start pulse and completion, and each scenario task compares the logs with hand-computed values.
module tb_dac_channel_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  // main instance (default TIMEOUT)
  logic [3:0]  wr = '0;
  logic [47:0] wdata = '0;
  logic [3:0]  pending, done_ch;
  logic        busy, timeout_err;
  logic        err_clr = 1'b0;
  logic [11:0] data;
  logic [3:0]  address, command;
  logic        dactrig;
  logic        dacdone = 1'b1;
  logic [1:0]  state_dbg;
  logic [3:0]  rr_ptr_dbg;

  // short-timeout instance, its wrapper never answers
  logic [3:0]  t2_wr = '0;
  logic [47:0] t2_wdata = '0;
  logic [3:0]  t2_pending, t2_done_ch;
  logic        t2_busy, t2_err;
  logic        t2_clr = 1'b0;
  logic [11:0] t2_data;
  logic [3:0]  t2_address, t2_command;
  logic        t2_dactrig;
  logic        t2_dacdone = 1'b1;
  logic [1:0]  t2_state;
  logic [3:0]  t2_rr;

  dac_channel_scheduler dut (
    .CLK50MHZ(clk), .RST(rst_n), .wr(wr), .wdata(wdata), .pending(pending),
    .done_ch(done_ch), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr),
    .data(data), .address(address), .command(command), .dactrig(dactrig),
    .dacdone(dacdone), .state_dbg(state_dbg), .rr_ptr_dbg(rr_ptr_dbg)
  );

  dac_channel_scheduler #(.TIMEOUT(20)) dut_to (
    .CLK50MHZ(clk), .RST(rst_n), .wr(t2_wr), .wdata(t2_wdata), .pending(t2_pending),
    .done_ch(t2_done_ch), .busy(t2_busy), .timeout_err(t2_err), .err_clr(t2_clr),
    .data(t2_data), .address(t2_address), .command(t2_command), .dactrig(t2_dactrig),
    .dacdone(t2_dacdone), .state_dbg(t2_state), .rr_ptr_dbg(t2_rr)
  );

  // clock / cycle counter
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // wrapper model: dacdone drops 2 cycles after the trigger is seen, returns 64 cycles later
  bit m_active = 1'b0;
  int m_t = 0;
  always @(posedge clk) begin
    if (m_active) begin
      if (m_t == 2) dacdone <= 1'b0;
      if (m_t == 66) begin
        dacdone  <= 1'b1;
        m_active <= 1'b0;
      end
      m_t <= m_t + 1;
    end else if (dactrig) begin
      m_active <= 1'b1;
      m_t      <= 1;
    end
  end

  // monitor: log {command,address,data} at each start pulse, and every done_ch pulse
  logic [19:0] trig_q[$];
  int          trig_cyc_q[$];
  logic [3:0]  done_q[$];
  int          done_cyc_q[$];
  logic [19:0] exp_q[$];
  logic [3:0]  exp_done_q[$];
  logic [19:0] hold_ref = '0;
  int          hold_viol = 0;

  always @(negedge clk) begin
    if (dactrig) begin
      trig_q.push_back({command, address, data});
      trig_cyc_q.push_back(cyc);
      hold_ref = {command, address, data};
    end
    if (rst_n && state_dbg >= 2'd2 && {command, address, data} !== hold_ref) hold_viol++;
    if (done_ch != 4'b0) begin
      done_q.push_back(done_ch);
      done_cyc_q.push_back(cyc);
    end
  end

  // driver tasks
  task automatic clear_logs();
    trig_q.delete(); trig_cyc_q.delete(); done_q.delete(); done_cyc_q.delete();
    exp_q.delete(); exp_done_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(busy == 1'b0 && pending == 4'b0 && !m_active && dacdone == 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n >= budget) begin
      n_miss++;
      $display("FAIL %s_idle: still busy after %0d cycles, required idle", tag, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_wait_done(input string tag);
    int n = 0;
    while (state_dbg != 2'd3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (state_dbg != 2'd3) begin
      n_miss++;
      $display("FAIL %s_reach_wait_done: state %0d, required 3", tag, state_dbg);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (pending !== 4'b0)     begin n_miss++; $display("FAIL rst_pending: got %b required 0000", pending); end
    n_vec++; if (done_ch !== 4'b0)     begin n_miss++; $display("FAIL rst_done_ch: got %b required 0000", done_ch); end
    n_vec++; if (busy !== 1'b0)        begin n_miss++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_vec++; if (timeout_err !== 1'b0) begin n_miss++; $display("FAIL rst_timeout_err: got %b required 0", timeout_err); end
    n_vec++; if (data !== 12'h000)     begin n_miss++; $display("FAIL rst_data: got %h required 000", data); end
    n_vec++; if (address !== 4'h0)     begin n_miss++; $display("FAIL rst_address: got %h required 0", address); end
    n_vec++; if (command !== 4'h3)     begin n_miss++; $display("FAIL rst_command: got %h required 3", command); end
    n_vec++; if (dactrig !== 1'b0)     begin n_miss++; $display("FAIL rst_dactrig: got %b required 0", dactrig); end
    n_vec++; if (state_dbg !== 2'd0)   begin n_miss++; $display("FAIL rst_state: got %0d required 0", state_dbg); end
    n_vec++; if (rr_ptr_dbg !== 4'd0)  begin n_miss++; $display("FAIL rst_rr_ptr: got %0d required 0", rr_ptr_dbg); end
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_single_write();
    int w;
    apply_reset();
    @(negedge clk);
    w = cyc; wr = 4'b0100; wdata = 48'hABC << 24;
    @(negedge clk);
    wr = 4'b0;
    n_vec++; if (pending !== 4'b0100) begin n_miss++; $display("FAIL single_pending_set: got %b required 0100", pending); end
    wait_idle(200, "single");
    n_vec++; if (trig_q.size() != 1) begin n_miss++; $display("FAIL single_trig_count: got %0d required 1", trig_q.size()); end
    n_vec++; if (trig_q.size() < 1 || trig_q[0] !== {4'h3, 4'h2, 12'hABC}) begin
      n_miss++; $display("FAIL single_xfer: got %h required 32abc", (trig_q.size() > 0) ? trig_q[0] : 20'hx); end
    n_vec++; if (trig_cyc_q.size() < 1 || trig_cyc_q[0] != w + 2) begin
      n_miss++; $display("FAIL single_trig_latency: got %0d required %0d", (trig_cyc_q.size() > 0) ? trig_cyc_q[0] : -1, w + 2); end
    n_vec++; if (done_q.size() != 1 || done_q[0] !== 4'b0100) begin
      n_miss++; $display("FAIL single_done: got %0d pulses required one 0100", done_q.size()); end
    n_vec++; if (done_cyc_q.size() < 1 || done_cyc_q[0] != w + 70) begin
      n_miss++; $display("FAIL single_done_latency: got %0d required %0d", (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, w + 70); end
    n_vec++; if (pending !== 4'b0) begin n_miss++; $display("FAIL single_pending_clear: got %b required 0000", pending); end
  endtask

  task automatic test_all_channels();
    int w;
    apply_reset();
    @(negedge clk);
    w = cyc; wr = 4'b1111; wdata = {12'h103, 12'h102, 12'h101, 12'h100};
    @(negedge clk);
    wr = 4'b0;
    wait_idle(400, "all");
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({4'h3, 4'(i), 12'h100 + 12'(i)});
      exp_done_q.push_back(4'b0001 << i);
    end
    n_vec++; if (trig_q.size() != 4) begin n_miss++; $display("FAIL all_trig_count: got %0d required 4", trig_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= trig_q.size() || trig_q[i] !== exp_q[i]) begin
        n_miss++; $display("FAIL all_xfer%0d: got %h required %h", i, (i < trig_q.size()) ? trig_q[i] : 20'hx, exp_q[i]); end
      n_vec++;
      if (i >= done_q.size() || done_q[i] !== exp_done_q[i]) begin
        n_miss++; $display("FAIL all_done%0d: got %b required %b", i, (i < done_q.size()) ? done_q[i] : 4'hx, exp_done_q[i]); end
    end
    for (int i = 1; i < trig_cyc_q.size(); i++) begin
      n_vec++;
      if (trig_cyc_q[i] - trig_cyc_q[i-1] != 69) begin
        n_miss++; $display("FAIL all_gap%0d: got %0d required 69", i, trig_cyc_q[i] - trig_cyc_q[i-1]); end
    end
    n_vec++; if (trig_cyc_q.size() < 1 || trig_cyc_q[0] != w + 2) begin
      n_miss++; $display("FAIL all_first_trig: got %0d required %0d", (trig_cyc_q.size() > 0) ? trig_cyc_q[0] : -1, w + 2); end
    n_vec++; if (rr_ptr_dbg !== 4'd0) begin n_miss++; $display("FAIL all_rr_ptr: got %0d required 0", rr_ptr_dbg); end
  endtask

  task automatic test_coalesce();
    apply_reset();
    @(negedge clk);
    wr = 4'b0001; wdata = 48'h050;
    @(negedge clk);
    wr = 4'b0;
    wait_wait_done("coalesce");
    @(negedge clk);
    wr = 4'b0010; wdata = 48'h111 << 12;
    @(negedge clk);
    wdata = 48'h222 << 12;
    @(negedge clk);
    wr = 4'b0;
    wait_idle(300, "coalesce");
    exp_q.push_back({4'h3, 4'h0, 12'h050});
    exp_q.push_back({4'h3, 4'h1, 12'h222});
    n_vec++; if (trig_q.size() != 2) begin n_miss++; $display("FAIL coalesce_count: got %0d required 2", trig_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (i >= trig_q.size() || trig_q[i] !== exp_q[i]) begin
        n_miss++; $display("FAIL coalesce_xfer%0d: got %h required %h", i, (i < trig_q.size()) ? trig_q[i] : 20'hx, exp_q[i]); end
    end
  endtask

  task automatic test_rewrite_on_grant();
    apply_reset();
    @(negedge clk);
    wr = 4'b1000; wdata = 48'h001 << 36;
    @(negedge clk);
    wdata = 48'h7FF << 36;
    @(negedge clk);
    wr = 4'b0;
    n_vec++; if (dactrig !== 1'b1) begin n_miss++; $display("FAIL rewrite_trig: got %b required 1", dactrig); end
    n_vec++; if (pending !== 4'b1000) begin n_miss++; $display("FAIL rewrite_pending: got %b required 1000", pending); end
    wait_idle(300, "rewrite");
    exp_q.push_back({4'h3, 4'h3, 12'h001});
    exp_q.push_back({4'h3, 4'h3, 12'h7FF});
    n_vec++; if (trig_q.size() != 2) begin n_miss++; $display("FAIL rewrite_count: got %0d required 2", trig_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (i >= trig_q.size() || trig_q[i] !== exp_q[i]) begin
        n_miss++; $display("FAIL rewrite_xfer%0d: got %h required %h", i, (i < trig_q.size()) ? trig_q[i] : 20'hx, exp_q[i]); end
    end
    n_vec++; if (done_q.size() != 2) begin n_miss++; $display("FAIL rewrite_done_count: got %0d required 2", done_q.size()); end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int k = 0; k < 220; k++) begin
      @(negedge clk);
      wr    = (k == 0) ? 4'b1001 : 4'b0001;
      wdata = {12'h333, 24'h0, 12'(k + 1)};
    end
    @(negedge clk);
    wr = 4'b0;
    wait_idle(300, "fair");
    exp_q.push_back({4'h3, 4'h0, 12'd1});
    exp_q.push_back({4'h3, 4'h3, 12'h333});
    exp_q.push_back({4'h3, 4'h0, 12'd139});
    exp_q.push_back({4'h3, 4'h0, 12'd208});
    exp_q.push_back({4'h3, 4'h0, 12'd220});
    n_vec++; if (trig_q.size() != 5) begin n_miss++; $display("FAIL fair_count: got %0d required 5", trig_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= trig_q.size() || trig_q[i] !== exp_q[i]) begin
        n_miss++; $display("FAIL fair_xfer%0d: got %h required %h", i, (i < trig_q.size()) ? trig_q[i] : 20'hx, exp_q[i]); end
    end
    n_vec++; if (hold_viol != 0) begin n_miss++; $display("FAIL hold_stable: got %0d changes required 0", hold_viol); end
  endtask

  task automatic test_timeout();
    int w, trig_c, err_c, trig_n, done_n, busy_at_err;
    // first stall: error is sticky until err_clr
    @(negedge clk);
    w = cyc; t2_wr = 4'b0010; t2_wdata = 48'h0AA << 12;
    @(negedge clk);
    t2_wr = 4'b0;
    trig_c = -1; err_c = -1; trig_n = 0; done_n = 0; busy_at_err = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (t2_dactrig) begin trig_n++; if (trig_c < 0) trig_c = cyc; end
      if (t2_done_ch != 4'b0) done_n++;
      if (t2_err && err_c < 0) begin err_c = cyc; busy_at_err = int'(t2_busy); end
    end
    n_vec++; if (trig_c != w + 2) begin n_miss++; $display("FAIL to_trig: got %0d required %0d", trig_c, w + 2); end
    n_vec++; if (err_c != w + 22) begin n_miss++; $display("FAIL to_err_cycle: got %0d required %0d", err_c, w + 22); end
    n_vec++; if (busy_at_err != 0) begin n_miss++; $display("FAIL to_idle: busy %0d required 0", busy_at_err); end
    n_vec++; if (done_n != 0) begin n_miss++; $display("FAIL to_no_done: got %0d pulses required 0", done_n); end
    n_vec++; if (trig_n != 1) begin n_miss++; $display("FAIL to_dropped: got %0d triggers required 1", trig_n); end
    n_vec++; if (t2_pending !== 4'b0) begin n_miss++; $display("FAIL to_pending: got %b required 0000", t2_pending); end
    n_vec++; if (t2_rr !== 4'd2) begin n_miss++; $display("FAIL to_rr_ptr: got %0d required 2", t2_rr); end
    n_vec++; if (t2_err !== 1'b1) begin n_miss++; $display("FAIL to_sticky: got %b required 1", t2_err); end
    t2_clr = 1'b1;
    @(negedge clk);
    n_vec++; if (t2_err !== 1'b0) begin n_miss++; $display("FAIL to_clear: got %b required 0", t2_err); end
    // second stall with err_clr held: set still wins on the timeout edge
    @(negedge clk);
    w = cyc; t2_wr = 4'b0010; t2_wdata = 48'h0BB << 12;
    @(negedge clk);
    t2_wr = 4'b0;
    err_c = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (t2_err && err_c < 0) err_c = cyc;
    end
    t2_clr = 1'b0;
    n_vec++; if (err_c != w + 22) begin n_miss++; $display("FAIL to_set_priority: got %0d required %0d", err_c, w + 22); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    wr = 4'b0100; wdata = 48'h5A5 << 24;
    @(negedge clk);
    wr = 4'b0;
    wait_wait_done("rstmid");
    done_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0)    begin n_miss++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    n_vec++; if (data !== 12'h0)   begin n_miss++; $display("FAIL rstmid_data: got %h required 000", data); end
    n_vec++; if (address !== 4'h0) begin n_miss++; $display("FAIL rstmid_address: got %h required 0", address); end
    n_vec++; if (command !== 4'h3) begin n_miss++; $display("FAIL rstmid_command: got %h required 3", command); end
    n_vec++; if (pending !== 4'b0) begin n_miss++; $display("FAIL rstmid_pending: got %b required 0000", pending); end
    n_vec++; if (rr_ptr_dbg !== 4'd0) begin n_miss++; $display("FAIL rstmid_rr_ptr: got %0d required 0", rr_ptr_dbg); end
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    n_vec++; if (done_q.size() != 0) begin n_miss++; $display("FAIL rstmid_no_done: got %0d pulses required 0", done_q.size()); end
    n_vec++; if (trig_q.size() != 1) begin n_miss++; $display("FAIL rstmid_no_retrigger: got %0d triggers required 1", trig_q.size()); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_all_channels();
    test_coalesce();
    test_rewrite_on_grant();
    test_fairness();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
